// File: rtl/bus_read_arbiter_if.sv
// Read-arbiter handshake bundle: master requests, shared AR/R handshakes,
// and the one-hot grant pair that steers the read mux.
interface bus_read_arbiter_if;
   logic m0_arvalid;
   logic m1_arvalid;
   logic arvalid;
   logic arready;
   logic rvalid;
   logic rready;
   logic rlast;
   logic m0_grnt;
   logic m1_grnt;
   logic busy;
   logic timeout_err;

   modport master (
      output m0_arvalid, m1_arvalid,
      output arvalid, arready,
      output rvalid, rready, rlast,
      input  m0_grnt, m1_grnt,
      input  busy, timeout_err
   );

   modport slave (
      input  m0_arvalid, m1_arvalid,
      input  arvalid, arready,
      input  rvalid, rready, rlast,
      output m0_grnt, m1_grnt,
      output busy, timeout_err
   );
endinterface

// File: rtl/bus_read_arbiter.sv
// Two-master read-channel arbiter: holds a one-hot grant from AR through
// the last R beat, with a watchdog that frees a hung transaction.
module bus_read_arbiter #(
   parameter bit          RR_EN   = 1'b1,
   parameter int unsigned TIMEOUT = 256,
   parameter int unsigned TO_W    = 16
) (
   input logic               clk,
   input logic               rst,
   bus_read_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA
   } state_e;

   localparam bit            WD_EN   = (TIMEOUT != 0);
   localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

   state_e          state_q, state_d;
   logic            m0_q, m0_d;
   logic            m1_q, m1_d;
   logic            busy_q, busy_d;
   logic            terr_q, terr_d;
   logic            last_q, last_d;
   logic [TO_W-1:0] wdog_q, wdog_d;

   logic any_req;
   logic pick_m1;
   logic ar_fire;
   logic r_done;
   logic wd_hit;
   logic fin;

   assign any_req = bus.m0_arvalid | bus.m1_arvalid;
   // last_q=1 means m1 owned last, so m0 takes a tie
   assign pick_m1 = bus.m1_arvalid
                  & (~bus.m0_arvalid | (RR_EN & ~last_q));
   assign ar_fire = bus.arvalid & bus.arready;
   assign r_done  = bus.rvalid & bus.rready & bus.rlast;
   assign wd_hit  = WD_EN && (wdog_q == WD_LAST);
   assign fin     = (state_q == DATA) && r_done;

   always_comb begin
      state_d = state_q;
      m0_d    = m0_q;
      m1_d    = m1_q;
      busy_d  = busy_q;
      terr_d  = 1'b0;
      last_d  = last_q;
      wdog_d  = wdog_q;
      unique case (1'b1)
         (state_q == IDLE): begin
            if (any_req) begin
               state_d = ADDR;
               m0_d    = ~pick_m1;
               m1_d    = pick_m1;
               busy_d  = 1'b1;
               wdog_d  = '0;
            end
         end
         (fin || wd_hit): begin
            // a completing last beat beats a same-cycle timeout
            state_d = IDLE;
            m0_d    = 1'b0;
            m1_d    = 1'b0;
            busy_d  = 1'b0;
            terr_d  = ~fin;
            last_d  = m1_q;
            wdog_d  = '0;
         end
         default: begin
            if (state_q == ADDR && ar_fire) begin
               state_d = DATA;
            end
            if (WD_EN) begin
               wdog_d = wdog_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         m0_q    <= 1'b0;
         m1_q    <= 1'b0;
         busy_q  <= 1'b0;
         terr_q  <= 1'b0;
         last_q  <= 1'b1;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         m0_q    <= m0_d;
         m1_q    <= m1_d;
         busy_q  <= busy_d;
         terr_q  <= terr_d;
         last_q  <= last_d;
         wdog_q  <= wdog_d;
      end
   end

   assign bus.m0_grnt     = m0_q;
   assign bus.m1_grnt     = m1_q;
   assign bus.busy        = busy_q;
   assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_bus_read_arbiter.sv
// Bench for bus_read_arbiter: two instances (round-robin + watchdog,
// fixed priority + no watchdog) driven in parallel against a model.
module tb_bus_read_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic m0 = 1'b0;
   logic m1 = 1'b0;
   logic arv = 1'b0;
   logic arr = 1'b0;
   logic rv = 1'b0;
   logic rr = 1'b0;
   logic rl = 1'b0;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   bus_read_arbiter_if ifa ();
   bus_read_arbiter_if ifb ();

   assign ifa.m0_arvalid = m0;
   assign ifa.m1_arvalid = m1;
   assign ifa.arvalid    = arv;
   assign ifa.arready    = arr;
   assign ifa.rvalid     = rv;
   assign ifa.rready     = rr;
   assign ifa.rlast      = rl;
   assign ifb.m0_arvalid = m0;
   assign ifb.m1_arvalid = m1;
   assign ifb.arvalid    = arv;
   assign ifb.arready    = arr;
   assign ifb.rvalid     = rv;
   assign ifb.rready     = rr;
   assign ifb.rlast      = rl;

   bus_read_arbiter #(
      .RR_EN   (1'b1),
      .TIMEOUT (8),
      .TO_W    (16)
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa.slave)
   );

   bus_read_arbiter #(
      .RR_EN   (1'b0),
      .TIMEOUT (0),
      .TO_W    (16)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb.slave)
   );

   // model: owner 0=none 1=m0 2=m1; age = cycles spent granted
   localparam int RR_CFG  [2] = '{1, 0};
   localparam int TMO_CFG [2] = '{8, 0};

   int own    [2] = '{0, 0};
   int lastm  [2] = '{1, 1};
   int age    [2] = '{0, 0};
   bit ardone [2] = '{1'b0, 1'b0};
   bit terr   [2] = '{1'b0, 1'b0};

   always @(posedge clk) begin : model
      int o, l, ag;
      bit ad, t;
      for (int k = 0; k < 2; k++) begin
         o  = own[k];
         l  = lastm[k];
         ag = age[k];
         ad = ardone[k];
         t  = 1'b0;
         if (rst) begin
            o  = 0;
            l  = 1;
            ag = 0;
            ad = 1'b0;
         end else if (o == 0) begin
            if (m0 || m1) begin
               if (m0 && m1)
                  o = (RR_CFG[k] != 0 && l == 0) ? 2 : 1;
               else
                  o = m0 ? 1 : 2;
               ad = 1'b0;
               ag = 0;
            end
         end else if (ad && rv && rr && rl) begin
            l = o - 1;
            o = 0;
         end else if (TMO_CFG[k] != 0 && ag == TMO_CFG[k] - 1) begin
            l = o - 1;
            o = 0;
            t = 1'b1;
         end else begin
            if (arv && arr) ad = 1'b1;
            ag = ag + 1;
         end
         own[k]    <= o;
         lastm[k]  <= l;
         age[k]    <= ag;
         ardone[k] <= ad;
         terr[k]   <= t;
      end
   end

   task automatic chk(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmp_a.m0_grnt", ifa.m0_grnt, own[0] == 1);
         chk("cmp_a.m1_grnt", ifa.m1_grnt, own[0] == 2);
         chk("cmp_a.busy", ifa.busy, own[0] != 0);
         chk("cmp_a.timeout_err", ifa.timeout_err, terr[0]);
         chk("cmp_b.m0_grnt", ifb.m0_grnt, own[1] == 1);
         chk("cmp_b.m1_grnt", ifb.m1_grnt, own[1] == 2);
         chk("cmp_b.busy", ifb.busy, own[1] != 0);
         chk("cmp_b.timeout_err", ifb.timeout_err, terr[1]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // starts in the first granted cycle, ends in the cycle after rlast
   task automatic txn(input int ar_wait, input int beats);
      arv = 1'b1;
      repeat (ar_wait) tick();
      arr = 1'b1;
      tick();
      arv = 1'b0;
      arr = 1'b0;
      rv  = 1'b1;
      rr  = 1'b1;
      for (int i = 0; i < beats; i++) begin
         rl = (i == beats - 1);
         tick();
      end
      rv = 1'b0;
      rr = 1'b0;
      rl = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      // T1 reset with both requests high
      m0 = 1'b1;
      m1 = 1'b1;
      tick();
      chk_en = 1'b1;
      tick();
      tick();
      chk("t1.a.m0_grnt", ifa.m0_grnt, 1'b0);
      chk("t1.a.m1_grnt", ifa.m1_grnt, 1'b0);
      chk("t1.a.busy", ifa.busy, 1'b0);
      chk("t1.a.terr", ifa.timeout_err, 1'b0);
      rst = 1'b0;
      m0  = 1'b0;
      m1  = 1'b0;
      tick();

      // T2 single m1 request, AR in cycle 3, 4 beats
      m1 = 1'b1;
      tick();
      chk("t2.a.m1_grnt", ifa.m1_grnt, 1'b1);
      chk("t2.a.m0_grnt", ifa.m0_grnt, 1'b0);
      m1 = 1'b0;
      txn(2, 4);
      chk("t2.a.m1_rel", ifa.m1_grnt, 1'b0);
      chk("t2.a.busy_rel", ifa.busy, 1'b0);
      tick();

      // T3/T4 both request for 3 transactions
      m0 = 1'b1;
      m1 = 1'b1;
      do_reset();
      tick();
      chk("t3.a.first_m0", ifa.m0_grnt, 1'b1);
      chk("t4.b.first_m0", ifb.m0_grnt, 1'b1);
      txn(0, 1);
      chk("t3.a.gap1_m0", ifa.m0_grnt, 1'b0);
      chk("t3.a.gap1_m1", ifa.m1_grnt, 1'b0);
      chk("t4.b.gap1_m0", ifb.m0_grnt, 1'b0);
      tick();
      chk("t3.a.second_m1", ifa.m1_grnt, 1'b1);
      chk("t4.b.second_m0", ifb.m0_grnt, 1'b1);
      txn(0, 1);
      chk("t3.a.gap2_m1", ifa.m1_grnt, 1'b0);
      tick();
      chk("t3.a.third_m0", ifa.m0_grnt, 1'b1);
      chk("t4.b.third_m0", ifb.m0_grnt, 1'b1);
      chk("t4.b.third_m1", ifb.m1_grnt, 1'b0);
      txn(0, 1);
      m0 = 1'b0;
      m1 = 1'b0;
      tick();

      // T5 watchdog on a stuck AR with m1 pending
      do_reset();
      m0 = 1'b1;
      tick();
      chk("t5.a.m0_grnt", ifa.m0_grnt, 1'b1);
      m0  = 1'b0;
      m1  = 1'b1;
      arv = 1'b1;
      repeat (7) tick();
      chk("t5.a.held_8th", ifa.m0_grnt, 1'b1);
      chk("t5.a.no_terr_yet", ifa.timeout_err, 1'b0);
      tick();
      chk("t5.a.terr", ifa.timeout_err, 1'b1);
      chk("t5.a.m0_drop", ifa.m0_grnt, 1'b0);
      chk("t5.a.m1_gap", ifa.m1_grnt, 1'b0);
      chk("t5.b.m0_held", ifb.m0_grnt, 1'b1);
      chk("t5.b.no_terr", ifb.timeout_err, 1'b0);
      tick();
      chk("t5.a.m1_grnt", ifa.m1_grnt, 1'b1);
      chk("t5.a.terr_pulse", ifa.timeout_err, 1'b0);
      m1  = 1'b0;
      arv = 1'b0;
      tick();

      // T6 rlast exactly on the last watchdog count
      do_reset();
      m0 = 1'b1;
      tick();
      m0 = 1'b0;
      txn(2, 5);
      chk("t6.a.no_terr", ifa.timeout_err, 1'b0);
      chk("t6.a.m0_rel", ifa.m0_grnt, 1'b0);
      chk("t6.a.busy_rel", ifa.busy, 1'b0);
      tick();

      // reset asserted during DATA
      m1 = 1'b1;
      tick();
      m1  = 1'b0;
      arv = 1'b1;
      arr = 1'b1;
      tick();
      arv = 1'b0;
      arr = 1'b0;
      rv  = 1'b1;
      rr  = 1'b1;
      rst = 1'b1;
      tick();
      chk("t6.rst.a.m1_grnt", ifa.m1_grnt, 1'b0);
      chk("t6.rst.a.busy", ifa.busy, 1'b0);
      chk("t6.rst.b.m1_grnt", ifb.m1_grnt, 1'b0);
      rst = 1'b0;
      rv  = 1'b0;
      rr  = 1'b0;
      tick();
      chk("t6.rst.a.idle", ifa.busy, 1'b0);
      m0 = 1'b1;
      tick();
      chk("t6.rst.a.regrant", ifa.m0_grnt, 1'b1);
      m0 = 1'b0;
      txn(0, 1);
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
